upcounter_ctrl: RTL and testbench
=================================

// Module: upcounter_ctrl
// PURPOSE
//  Sequencer for the team's 8-bit up-counter (enable + sync-clear variant).
//  Takes start/stop/pause commands, applies a programmable clock prescaler,
//  and detects a programmable terminal count. One-shot or auto-reload modes.
//  Drives the counter's clear/enable and observes its Q; no counting logic here.
// PARAMETERS
//  WIDTH    8  width of counter value and terminal value
//  PRESC_W  4  width of prescaler divide field
// PORTS
//  clk          in   1        single clock; all state changes on posedge
//  reset        in   1        asynchronous, active-low; clears all state
//  start        in   1        level-sampled; begins a run when IDLE
//  stop         in   1        abort run, return to IDLE
//  pause        in   1        freeze counting while high (RUN<->HOLD)
//  mode_reload  in   1        1=auto-reload at terminal, 0=one-shot; latched at start
//  term_val     in   WIDTH    terminal count T; latched at start
//  presc_div    in   PRESC_W  prescaler P: one increment per P+1 RUN cycles; latched
//  cnt_q        in   WIDTH    current value of controlled counter
//  cnt_clr      out  1        sync clear to counter (registered)
//  cnt_en       out  1        increment enable to counter (combinational)
//  busy         out  1        state != IDLE
//  done         out  1        one-cycle pulse per terminal-count event (registered)
//  reload_cnt   out  8        reloads since start, saturates at 255
//  state        out  2        IDLE=00 ARM=01 RUN=10 HOLD=11
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cnt_clr=0, cnt_en=0, busy=0, done=0,
//   reload_cnt=0, prescaler=0, latched T/P/mode=0. Reset mid-run aborts, no done.
//  Priority each edge: stop > terminal > pause > start.
//  IDLE: start=1 & stop=0 -> latch T,P,mode; reload_cnt<=0; -> ARM.
//  ARM (1 cycle): cnt_clr=1, prescaler<=0; -> RUN (counter is 0 on RUN entry).
//  RUN: terminal when cnt_q==T. Else prescaler++; cnt_en=1 iff prescaler==P,
//   then prescaler<=0. cnt_en=0 in all other states and in terminal cycle.
//  Terminal in RUN: done<=1 next cycle; mode=0 -> IDLE; mode=1 -> ARM,
//   reload_cnt++ (hold at 255).
//  pause=1 in RUN (no terminal) -> HOLD; prescaler and counter frozen.
//  HOLD: pause=0 -> RUN, prescaler resumes from held value. Terminal not
//   evaluated in HOLD.
//  stop=1 in ARM/RUN/HOLD -> IDLE next edge, done not asserted, reload_cnt kept.
//  start while not IDLE: ignored. start&stop in IDLE: stay IDLE.
//  T=0: terminal on first RUN cycle; done one cycle after ARM's exit edge.
//  Latency: start sampled at edge E0; done high for the cycle after edge
//   E(2 + T*(P+1)). Auto-reload period: 1 + T*(P+1) + 1 cycles per done.
//  Inputs T,P,mode changing mid-run have no effect until next start.
//  cnt_q is trusted; a value > T (external corruption) never terminates:
//   counter wraps 255->0 and run continues to T.
// TESTING
//  1. Reset mid-RUN (reset=0 for 1 cycle) -> all outputs 0, state=00, no done.
//  2. One-shot T=3,P=0, start at E0 -> cnt_clr high E0..E1, cnt_en high 3
//     cycles, done high after E5 exactly 1 cycle, busy low same cycle.
//  3. Reload T=2,P=1 -> done every 6 cycles; reload_cnt 1,2,3...; stop ->
//     IDLE next edge, no done, reload_cnt retained.
//  4. T=5,P=0, pause high 4 cycles at cnt_q=2 -> state=HOLD, cnt_q stays 2,
//     done delayed by exactly 4 cycles vs. uninterrupted run.
//  5. T=0 -> done one cycle after RUN entry; start&stop together in IDLE ->
//     stays IDLE; start while RUN -> no relatch (change term_val, T unchanged).
//  6. Reload T=1,P=0 run >300 events -> reload_cnt saturates at 255.

Source files
------------

// File: rtl/upcounter_ctrl.sv
// rtl/upcounter_ctrl.sv - start/stop/pause sequencer with prescaler and terminal detect for an 8-bit up-counter
module upcounter_ctrl #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               mode_reload,
   input  logic [WIDTH-1:0]   term_val,
   input  logic [PRESC_W-1:0] presc_div,
   input  logic [WIDTH-1:0]   cnt_q,
   output logic               cnt_clr,
   output logic               cnt_en,
   output logic               busy,
   output logic               done,
   output logic [7:0]         reload_cnt,
   output logic [1:0]         state
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_ARM  = 2'b01;
   localparam logic [1:0] S_RUN  = 2'b10;
   localparam logic [1:0] S_HOLD = 2'b11;

   logic [1:0]         state_r;
   logic [1:0]         state_nx;
   logic [WIDTH-1:0]   term_r;
   logic [PRESC_W-1:0] presc_r;
   logic [PRESC_W-1:0] presc_cnt;
   logic               mode_r;
   logic               terminal;
   logic               presc_hit;
   logic               launch;

   assign terminal  = (state_r == S_RUN) && (cnt_q == term_r);
   assign presc_hit = (presc_cnt == presc_r);
   assign launch    = (state_r == S_IDLE) && start && !stop;
   assign state     = state_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
         cnt_clr <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nx;
         cnt_clr <= (state_nx == S_ARM);
         done    <= terminal && !stop;
      end
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         S_IDLE: if (launch) state_nx = S_ARM;
         S_ARM:  state_nx = stop ? S_IDLE : S_RUN;
         S_RUN: begin
            if (stop)          state_nx = S_IDLE;
            else if (terminal) state_nx = mode_r ? S_ARM : S_IDLE;
            else if (pause)    state_nx = S_HOLD;
         end
         S_HOLD: begin
            if (stop)        state_nx = S_IDLE;
            else if (!pause) state_nx = S_RUN;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // A pausing RUN cycle still counts; only HOLD itself is frozen.
   always_comb begin
      cnt_en = (state_r == S_RUN) && !terminal && presc_hit;
      busy   = (state_r != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         term_r     <= '0;
         presc_r    <= '0;
         mode_r     <= 1'b0;
         presc_cnt  <= '0;
         reload_cnt <= 8'd0;
      end else begin
         if (launch) begin
            term_r     <= term_val;
            presc_r    <= presc_div;
            mode_r     <= mode_reload;
            reload_cnt <= 8'd0;
         end
         if (state_r == S_ARM)
            presc_cnt <= '0;
         else if ((state_r == S_RUN) && !stop && !terminal)
            presc_cnt <= presc_hit ? '0 : presc_cnt + 1'b1;
         if (terminal && !stop && mode_r && (reload_cnt != 8'hFF))
            reload_cnt <= reload_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_upcounter_ctrl.sv
// tb/tb_upcounter_ctrl.sv - scoreboard bench for upcounter_ctrl driving a behavioural 8-bit counter
module tb_upcounter_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic       mode_reload = 1'b0;
   logic [7:0] term_val = 8'd0;
   logic [3:0] presc_div = 4'd0;
   logic [7:0] cnt_q = 8'd0;
   logic       cnt_clr;
   logic       cnt_en;
   logic       busy;
   logic       done;
   logic [7:0] reload_cnt;
   logic [1:0] state;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] rc;
      logic       busy;
   } exp_t;
   exp_t sb[$];

   upcounter_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .mode_reload(mode_reload), .term_val(term_val), .presc_div(presc_div),
      .cnt_q(cnt_q), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy),
      .done(done), .reload_cnt(reload_cnt), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (cnt_clr)     cnt_q <= 8'd0;
      else if (cnt_en) cnt_q <= cnt_q + 8'd1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL done_missing: got none expected done at cyc %0d", sb[0].cyc);
         void'(sb.pop_front());
      end
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got done=1 expected 0 (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_reload_cnt", int'(reload_cnt), int'(e.rc));
            chk("done_busy", int'(busy), int'(e.busy));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wait_idle(input string name, input int limit);
      for (int i = 0; i < limit && state != 2'b00; i++) tick();
      chk(name, int'(state), 0);
   endtask

   task automatic push(input int c, input int rc, input int b);
      exp_t e;
      e.cyc  = c;
      e.rc   = rc[7:0];
      e.busy = b[0];
      sb.push_back(e);
   endtask

   task automatic start_run(input int t, input int p, input int m, output int c);
      term_val    = t[7:0];
      presc_div   = p[3:0];
      mode_reload = m[0];
      start       = 1'b1;
      c           = cyc;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int c;
      int en_n;

      // reset state
      tick();
      tick();
      chk("rst_state", int'(state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cnt_clr", int'(cnt_clr), 0);
      chk("rst_cnt_en", int'(cnt_en), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_reload_cnt", int'(reload_cnt), 0);
      reset = 1'b1;
      tick();

      // one-shot T=3 P=0
      start_run(3, 0, 0, c);
      push(c + 6, 0, 0);
      chk("os_arm_state", int'(state), 1);
      chk("os_arm_clr", int'(cnt_clr), 1);
      chk("os_arm_busy", int'(busy), 1);
      en_n = 0;
      for (int i = 0; i < 20 && state != 2'b00; i++) begin
         if (cnt_en) en_n++;
         tick();
      end
      chk("os_en_cycles", en_n, 3);
      chk("os_end_state", int'(state), 0);
      tick();
      tick();

      // reset in the middle of an auto-reload run
      start_run(1, 0, 1, c);
      push(c + 4, 1, 1);
      wait_until(c + 5);
      chk("mid_state_run", int'(state), 2);
      reset = 1'b0;
      #1;
      chk("mid_rst_state", int'(state), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_reload", int'(reload_cnt), 0);
      chk("mid_rst_cnt_en", int'(cnt_en), 0);
      chk("mid_rst_cnt_clr", int'(cnt_clr), 0);
      chk("mid_rst_done", int'(done), 0);
      tick();
      reset = 1'b1;
      repeat (4) tick();

      // auto-reload T=2 P=1, then stop
      start_run(2, 1, 1, c);
      push(c + 7, 1, 1);
      push(c + 13, 2, 1);
      push(c + 19, 3, 1);
      wait_until(c + 21);
      chk("rl_reload_cnt", int'(reload_cnt), 3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("rl_stop_state", int'(state), 0);
      chk("rl_stop_busy", int'(busy), 0);
      chk("rl_stop_keep", int'(reload_cnt), 3);
      repeat (10) tick();

      // pause for 4 cycles: done shifts from c+8 to c+12
      start_run(5, 0, 0, c);
      push(c + 12, 0, 0);
      wait_until(c + 3);
      chk("ps_q_before", int'(cnt_q), 1);
      pause = 1'b1;
      wait_until(c + 5);
      chk("ps_hold_state", int'(state), 3);
      chk("ps_hold_q", int'(cnt_q), 2);
      wait_until(c + 7);
      chk("ps_hold_q_late", int'(cnt_q), 2);
      chk("ps_hold_en", int'(cnt_en), 0);
      pause = 1'b0;
      wait_idle("ps_idle", 30);
      tick();

      // T=0
      start_run(0, 0, 0, c);
      push(c + 3, 0, 0);
      tick();
      chk("t0_run_state", int'(state), 2);
      chk("t0_run_en", int'(cnt_en), 0);
      wait_idle("t0_idle", 10);
      tick();

      // start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_state", int'(state), 0);
      chk("ss_busy", int'(busy), 0);
      tick();

      // start while running does not relatch
      start_run(3, 0, 0, c);
      push(c + 6, 0, 0);
      wait_until(c + 2);
      term_val = 8'd1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("nr_state", int'(state), 2);
      wait_idle("nr_idle", 20);
      term_val = 8'd0;
      tick();

      // reload_cnt saturation over 300 events, period 3
      start_run(1, 0, 1, c);
      for (int k = 1; k <= 300; k++)
         push(c + 4 + 3 * (k - 1), (k > 255) ? 255 : k, 1);
      wait_until(c + 4 + 3 * 299);
      chk("sat_reload_cnt", int'(reload_cnt), 255);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("sat_stop_state", int'(state), 0);
      chk("sat_keep", int'(reload_cnt), 255);
      repeat (5) tick();

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
